// File: rtl/vme_interrupter.sv
// rtl/vme_interrupter.sv - VME interrupter: fixed-level IRQ, IACK daisy chain, ROAK release
module vme_interrupter #(
  parameter int LEVEL       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       irq_req,
  input  logic [7:0] vector,
  output logic       irq_pending,
  output logic       irq_acked,
  output logic [6:0] vme_irq_n,
  input  logic       vme_as_n,
  input  logic       vme_ds0_n,
  input  logic       vme_iack_n,
  input  logic       vme_iackin_n,
  output logic       vme_iackout_n,
  input  logic [2:0] vme_addr,
  output logic [7:0] vme_data,
  output logic       vme_data_oe,
  output logic       vme_dtack_n
);

  if (LEVEL < 1 || LEVEL > 7) begin : g_bad_level
    $error("vme_interrupter: LEVEL must be in 1..7");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("vme_interrupter: SYNC_STAGES must be at least 2");
  end

  localparam logic [2:0] LEVEL_A = 3'(LEVEL);
  localparam logic [6:0] IRQ_ON  = ~(7'b1 << (LEVEL - 1));
  localparam logic [6:0] SYNC_RST = 7'b000_1111;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_PASS, S_RESPOND, S_DTACK, S_FINISH
  } state_e;

  state_e     state_q;
  logic       pending_q, pending_d;
  logic [6:0] irq_n_q;
  logic       iackout_n_q, dtack_n_q, data_oe_q, acked_q;
  logic [7:0] data_q;

  // Address travels with the strobes so it is always consistent with iackin.
  logic [6:0] sync_q [SYNC_STAGES];
  logic       as_s, ds0_s, iack_s, iackin_s;
  logic [2:0] addr_s;
  logic       chain_sel, chain_idle, enter_respond;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= {vme_addr, vme_iackin_n, vme_iack_n, vme_ds0_n, vme_as_n};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {addr_s, iackin_s, iack_s, ds0_s, as_s} = sync_q[SYNC_STAGES-1];
  assign chain_sel     = ~iackin_s & ~iack_s & ~as_s;
  assign chain_idle    = iackin_s & as_s;
  assign enter_respond = (state_q == S_REQ) && chain_sel && (addr_s == LEVEL_A);
  // A request landing on the acknowledge cycle survives as a fresh interrupt.
  assign pending_d     = irq_req | (pending_q & ~enter_respond);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      irq_n_q     <= 7'h7F;
      iackout_n_q <= 1'b1;
      dtack_n_q   <= 1'b1;
      data_oe_q   <= 1'b0;
      data_q      <= 8'h00;
      acked_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      acked_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pending_q) begin
            state_q <= S_REQ;
            irq_n_q <= IRQ_ON;
          end else if (chain_sel) begin
            state_q     <= S_PASS;
            iackout_n_q <= 1'b0;
          end
        end
        S_REQ: begin
          if (enter_respond) begin
            state_q <= S_RESPOND;
            data_q  <= vector;
          end else if (chain_sel) begin
            state_q     <= S_PASS;
            iackout_n_q <= 1'b0;
          end
        end
        S_PASS: begin
          if (chain_idle) begin
            iackout_n_q <= 1'b1;
            if (pending_q) begin
              state_q <= S_REQ;
              irq_n_q <= IRQ_ON;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_RESPOND: begin
          state_q   <= S_DTACK;
          data_oe_q <= 1'b1;
          irq_n_q   <= 7'h7F;
        end
        // DTACK follows oe by a cycle so data is set up before the strobe.
        S_DTACK: begin
          if (ds0_s) begin
            state_q   <= S_FINISH;
            dtack_n_q <= 1'b1;
            data_oe_q <= 1'b0;
            acked_q   <= 1'b1;
          end else begin
            dtack_n_q <= 1'b0;
          end
        end
        S_FINISH: begin
          if (chain_idle) begin
            if (pending_q) begin
              state_q <= S_REQ;
              irq_n_q <= IRQ_ON;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign irq_pending   = pending_q;
  assign irq_acked     = acked_q;
  assign vme_irq_n     = irq_n_q;
  assign vme_iackout_n = iackout_n_q;
  assign vme_data      = data_q;
  assign vme_data_oe   = data_oe_q;
  assign vme_dtack_n   = dtack_n_q;

endmodule

// File: tb/tb_vme_interrupter.sv
// tb/tb_vme_interrupter.sv - bench for vme_interrupter: timing sequences, vector table, random IACK traffic
module tb_vme_interrupter;

  localparam int LEVEL = 2;
  localparam logic [6:0] IRQ_LOW = 7'b1111101;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       irq_req = 1'b0;
  logic [7:0] vector = 8'h00;
  logic       irq_pending, irq_acked;
  logic [6:0] vme_irq_n;
  logic       vme_as_n = 1'b1, vme_ds0_n = 1'b1, vme_iack_n = 1'b1, vme_iackin_n = 1'b1;
  logic       vme_iackout_n;
  logic [2:0] vme_addr = 3'd0;
  logic [7:0] vme_data;
  logic       vme_data_oe, vme_dtack_n;

  vme_interrupter #(.LEVEL(LEVEL), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .irq_req(irq_req), .vector(vector),
    .irq_pending(irq_pending), .irq_acked(irq_acked), .vme_irq_n(vme_irq_n),
    .vme_as_n(vme_as_n), .vme_ds0_n(vme_ds0_n), .vme_iack_n(vme_iack_n),
    .vme_iackin_n(vme_iackin_n), .vme_iackout_n(vme_iackout_n), .vme_addr(vme_addr),
    .vme_data(vme_data), .vme_data_oe(vme_data_oe), .vme_dtack_n(vme_dtack_n)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, total_cnt = 0;
  int acked_cnt;
  logic seen_dtack, seen_pass, seen_oe, oe_at_dtack;
  logic [7:0] data_cap;
  logic m_pend;

  typedef struct {
    int         nreq;
    logic [2:0] addr;
    logic [7:0] vec;
    logic       resp;
    logic [6:0] irq;
  } row_t;
  row_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (irq_acked) acked_cnt++;
    if (!vme_dtack_n && !seen_dtack) begin
      seen_dtack  = 1'b1;
      data_cap    = vme_data;
      oe_at_dtack = vme_data_oe;
    end
    if (!vme_iackout_n) seen_pass = 1'b1;
    if (vme_data_oe) seen_oe = 1'b1;
  endtask

  task automatic clear_obs();
    acked_cnt = 0; seen_dtack = 1'b0; seen_pass = 1'b0; seen_oe = 1'b0;
    oe_at_dtack = 1'b0; data_cap = 8'h00;
  endtask

  task automatic strobes(input logic lvl);
    vme_as_n = lvl; vme_iack_n = lvl; vme_iackin_n = lvl; vme_ds0_n = lvl;
  endtask

  task automatic do_reset();
    reset = 1'b1; strobes(1'b1); irq_req = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic pulse_req();
    irq_req = 1'b1; step(); irq_req = 1'b0; step();
  endtask

  task automatic run_txn(input int nreq, input logic [2:0] a, input logic [7:0] vec,
                         input logic exp_resp, input logic [6:0] exp_irq, input string tag);
    for (int k = 0; k < nreq; k++) pulse_req();
    step(); step();
    clear_obs();
    vector = vec; vme_addr = a; strobes(1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      if (seen_dtack || seen_pass) break;
    end
    vme_ds0_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    strobes(1'b1);
    for (int i = 0; i < 6; i++) step();
    chk({tag, " dtack"}, int'(seen_dtack), int'(exp_resp));
    chk({tag, " pass"}, int'(seen_pass), int'(!exp_resp));
    chk({tag, " oe_seen"}, int'(seen_oe), int'(exp_resp));
    chk({tag, " acked"}, acked_cnt, int'(exp_resp));
    if (exp_resp) begin
      chk({tag, " data"}, int'(data_cap), int'(vec));
      chk({tag, " oe_at_dtack"}, int'(oe_at_dtack), 1);
    end
    chk({tag, " irq_n"}, int'(vme_irq_n), int'(exp_irq));
    chk({tag, " pending"}, int'(irq_pending), int'(exp_irq != 7'h7F));
    chk({tag, " iackout_idle"}, int'(vme_iackout_n), 1);
  endtask

  initial begin
    clear_obs();
    do_reset();
    chk("reset irq_n", int'(vme_irq_n), int'(7'h7F));
    chk("reset iackout", int'(vme_iackout_n), 1);
    chk("reset dtack", int'(vme_dtack_n), 1);
    chk("reset oe", int'(vme_data_oe), 0);
    chk("reset data", int'(vme_data), 0);
    chk("reset acked", int'(irq_acked), 0);
    chk("reset pending", int'(irq_pending), 0);

    irq_req = 1'b1; step(); irq_req = 1'b0;
    chk("req pending+1", int'(irq_pending), 1);
    chk("req irq+1", int'(vme_irq_n), int'(7'h7F));
    step();
    chk("req irq+2", int'(vme_irq_n), int'(IRQ_LOW));

    // Matching IACK, cycle-exact.
    vector = 8'hA5; vme_addr = 3'd2; strobes(1'b0);
    step(); step(); step();
    chk("match data", int'(vme_data), int'(8'hA5));
    chk("match oe_early", int'(vme_data_oe), 0);
    step();
    chk("match oe", int'(vme_data_oe), 1);
    chk("match irq_release", int'(vme_irq_n), int'(7'h7F));
    chk("match dtack_late", int'(vme_dtack_n), 1);
    step();
    chk("match dtack", int'(vme_dtack_n), 0);
    clear_obs();
    vme_ds0_n = 1'b1;
    step(); step();
    chk("ds0 dtack_hold", int'(vme_dtack_n), 0);
    step();
    chk("ds0 dtack_rel", int'(vme_dtack_n), 1);
    chk("ds0 oe_rel", int'(vme_data_oe), 0);
    chk("ds0 acked", int'(irq_acked), 1);
    step();
    chk("ds0 acked_pulse", int'(irq_acked), 0);
    strobes(1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("match acked_once", acked_cnt, 1);
    chk("match pending", int'(irq_pending), 0);

    // Daisy chain with nothing pending.
    clear_obs();
    vme_as_n = 1'b0; vme_iack_n = 1'b0; vme_addr = 3'd2;
    step(); step(); step();
    vme_iackin_n = 1'b0;
    step(); step();
    chk("chain iackout+2", int'(vme_iackout_n), 1);
    step();
    chk("chain iackout+3", int'(vme_iackout_n), 0);
    vme_iackin_n = 1'b1; vme_as_n = 1'b1;
    step(); step();
    chk("chain rel+2", int'(vme_iackout_n), 0);
    step();
    chk("chain rel+3", int'(vme_iackout_n), 1);
    vme_iack_n = 1'b1;
    step();
    chk("chain no_oe", int'(seen_oe), 0);
    chk("chain no_dtack", int'(seen_dtack), 0);

    // Non-matching IACK while pending.
    pulse_req(); step();
    clear_obs();
    vme_addr = 3'd5; strobes(1'b0);
    step(); step();
    chk("nomatch iackout+2", int'(vme_iackout_n), 1);
    step();
    chk("nomatch iackout+3", int'(vme_iackout_n), 0);
    for (int i = 0; i < 6; i++) step();
    chk("nomatch no_oe", int'(seen_oe), 0);
    chk("nomatch no_dtack", int'(seen_dtack), 0);
    chk("nomatch irq", int'(vme_irq_n), int'(IRQ_LOW));
    strobes(1'b1);
    step(); step(); step();
    chk("nomatch iackout_rel", int'(vme_iackout_n), 1);
    chk("nomatch irq_after", int'(vme_irq_n), int'(IRQ_LOW));
    chk("nomatch pending", int'(irq_pending), 1);

    // Request on the RESPOND-entry edge.
    clear_obs();
    vector = 8'h77; vme_addr = 3'd2; strobes(1'b0);
    step(); step();
    irq_req = 1'b1;
    step();
    irq_req = 1'b0; vector = 8'h3C;
    chk("same_edge pending", int'(irq_pending), 1);
    chk("same_edge data", int'(vme_data), int'(8'h77));
    step(); step();
    chk("same_edge dtack", int'(vme_dtack_n), 0);
    vme_ds0_n = 1'b1;
    step(); step(); step();
    chk("same_edge acked", int'(irq_acked), 1);
    strobes(1'b1);
    step(); step();
    chk("same_edge irq_wait", int'(vme_irq_n), int'(7'h7F));
    step();
    chk("same_edge irq_reassert", int'(vme_irq_n), int'(IRQ_LOW));
    run_txn(0, 3'd2, 8'h3C, 1'b1, 7'h7F, "second_iack");

    // Reset in the middle of DTACK.
    pulse_req(); step();
    vme_addr = 3'd2; vector = 8'h99; strobes(1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("rst_dtack pre", int'(vme_dtack_n), 0);
    clear_obs();
    reset = 1'b1;
    step();
    chk("rst_dtack dtack", int'(vme_dtack_n), 1);
    chk("rst_dtack oe", int'(vme_data_oe), 0);
    chk("rst_dtack irq", int'(vme_irq_n), int'(7'h7F));
    chk("rst_dtack pending", int'(irq_pending), 0);
    strobes(1'b1);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("rst_dtack no_acked", acked_cnt, 0);

    tbl[0] = '{1, 3'd2, 8'h5A, 1'b1, 7'h7F};
    tbl[1] = '{0, 3'd2, 8'h11, 1'b0, 7'h7F};
    tbl[2] = '{1, 3'd5, 8'h22, 1'b0, IRQ_LOW};
    tbl[3] = '{0, 3'd2, 8'hC3, 1'b1, 7'h7F};
    tbl[4] = '{3, 3'd2, 8'h0F, 1'b1, 7'h7F};
    tbl[5] = '{1, 3'd7, 8'h44, 1'b0, IRQ_LOW};
    tbl[6] = '{0, 3'd1, 8'h55, 1'b0, IRQ_LOW};
    tbl[7] = '{0, 3'd2, 8'hFF, 1'b1, 7'h7F};
    do_reset();
    for (int r = 0; r < 8; r++)
      run_txn(tbl[r].nreq, tbl[r].addr, tbl[r].vec, tbl[r].resp, tbl[r].irq,
              $sformatf("tbl%0d", r));

    // Random traffic against the acknowledge-rule model.
    do_reset();
    m_pend = 1'b0;
    for (int t = 0; t < 30; t++) begin
      int         nreq;
      logic [2:0] a;
      logic [7:0] vec;
      logic       exp_resp;
      logic [6:0] exp_irq;
      nreq = int'($urandom_range(0, 2));
      a    = ($urandom % 2 == 0) ? 3'(LEVEL) : 3'($urandom_range(1, 7));
      vec  = 8'($urandom);
      if (nreq > 0) m_pend = 1'b1;
      exp_resp = m_pend && (int'(a) == LEVEL);
      if (exp_resp) m_pend = 1'b0;
      exp_irq = m_pend ? IRQ_LOW : 7'h7F;
      run_txn(nreq, a, vec, exp_resp, exp_irq, $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
